// File: rtl/fifo_drain_streamer.sv
// FIFO read-side drainer: pops into a 2-entry skid buffer, tags frame ends, counts accepted frames.
// Optional FIFO_DRAIN_STREAMER_PARITY_EN adds a stored even-parity bit on m_parity.
module fifo_drain_streamer #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
`ifdef FIFO_DRAIN_STREAMER_PARITY_EN
    output logic             m_parity,
`endif
    output logic [15:0]      frame_cnt
);
    typedef struct packed {
`ifdef FIFO_DRAIN_STREAMER_PARITY_EN
        logic             parity;
`endif
        logic             last;
        logic [WIDTH-1:0] data;
    } entry_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    entry_t     ent_q [2];
    entry_t     head_ent;
    entry_t     push_ent;
    logic [1:0] count;
    logic       head;
    logic       tail;
    logic [7:0] word_idx;
    logic       push;
    logic       pop;

    // Gated by rst_n so the FIFO is never popped while reset holds count at 0.
    assign push       = rst_n && enable && !fifo_empty && (count != 2'd2);
    assign fifo_rd_en = push;
    assign m_valid    = (count != 2'd0);
    assign pop        = m_valid && m_ready;

    assign head_ent = ent_q[head];
    assign m_data   = head_ent.data;
    assign m_last   = head_ent.last;
`ifdef FIFO_DRAIN_STREAMER_PARITY_EN
    assign m_parity = head_ent.parity;
`endif

    always_comb begin
        push_ent      = '0;
        push_ent.data = fifo_data;
        push_ent.last = (word_idx == LAST_IDX);
`ifdef FIFO_DRAIN_STREAMER_PARITY_EN
        push_ent.parity = ^fifo_data;
`endif
    end

    // Entries are cleared on reset so the head reads back as all-zero outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[0]  <= '0;
            ent_q[1]  <= '0;
            count     <= 2'd0;
            head      <= 1'b0;
            tail      <= 1'b0;
            word_idx  <= 8'd0;
            frame_cnt <= 16'd0;
        end else begin
            if (push) begin
                ent_q[tail] <= push_ent;
                tail        <= ~tail;
                word_idx    <= (word_idx == LAST_IDX) ? 8'd0 : word_idx + 8'd1;
            end
            if (pop) begin
                head <= ~head;
                if (head_ent.last)
                    frame_cnt <= frame_cnt + 16'd1;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
